// File: rtl/cnn_pkg.sv
// Shared defaults, FSM state encoding and index-width helper for the CNN MAC scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

  // Default geometry: inputs per neuron, neurons per frame, operand and accumulator widths.
  localparam int CNN_N_IN  = 16;
  localparam int CNN_N_OUT = 4;
  localparam int CNN_DW    = 8;
  localparam int CNN_AW    = 16;

  // Scheduler sequencing: stream operands, drain MAC pipeline, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } state_e;

  // Index width that never collapses to zero bits for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_idx_counter.sv
// Wrapping index counter 0..MAX-1 with synchronous clear, enable and terminal-count flag.
// Latency: count updates on the edge that samples en/clr; tc is combinational from the count.
// Backpressure: none; the owner gates en.
module cnn_idx_counter
  import cnn_pkg::*;
#(
  parameter  int MAX = 16,
  localparam int W   = idx_w(MAX)
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == W'(MAX - 1));
  assign cnt = cnt_q;

  // Next count: clear has priority, otherwise step and wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cnn_mac_scheduler.sv
// Sequences buffer reads and MAC strobes for N_OUT neurons of N_IN inputs each, then emits each sum.
// Latency: N_IN read cycles + 2 drain cycles + 1 emit cycle per neuron (N_IN+3 with out_ready high).
// Backpressure: out_valid/out_data/out_idx hold in EMIT until out_ready; no reads issue while stalled.
module cnn_mac_scheduler
  import cnn_pkg::*;
#(
  parameter  int N_IN  = CNN_N_IN,
  parameter  int N_OUT = CNN_N_OUT,
  parameter  int DW    = CNN_DW,
  parameter  int AW    = CNN_AW,
  localparam int IW    = idx_w(N_IN),
  localparam int WW    = idx_w(N_IN * N_OUT),
  localparam int OW    = idx_w(N_OUT)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  output logic [IW-1:0] in_addr,
  output logic [WW-1:0] w_addr,
  output logic          rd_en,
  input  logic [DW-1:0] in_rdata,
  input  logic [DW-1:0] w_rdata,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic          mac_en,
  output logic          mac_clr,
  input  logic [AW-1:0] mac_acc,
  output logic [AW-1:0] out_data,
  output logic [OW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic          wait_q, wait_d;        // 0 in first drain cycle, 1 in second
  logic          mac_en_q, mac_en_d;
  logic          mac_clr_q, mac_clr_d;
  logic          done_q, done_d;
  logic [AW-1:0] out_data_q, out_data_d;
  logic [OW-1:0] out_idx_q, out_idx_d;

  logic [IW-1:0] i_cnt;
  logic          i_tc, i_clr, i_en;
  logic [OW-1:0] n_cnt;
  logic          n_tc, n_clr, n_en;

  // Input index within the current neuron.
  cnn_idx_counter #(.MAX(N_IN)) u_i_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .clr (i_clr),
    .en  (i_en),
    .cnt (i_cnt),
    .tc  (i_tc)
  );

  // Neuron index within the frame.
  cnn_idx_counter #(.MAX(N_OUT)) u_n_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .clr (n_clr),
    .en  (n_en),
    .cnt (n_cnt),
    .tc  (n_tc)
  );

  // Operands come straight from the buffers; the read strobe already lined them up with mac_en.
  assign mac_a    = in_rdata;
  assign mac_b    = w_rdata;
  assign mac_en   = mac_en_q;
  assign mac_clr  = mac_clr_q;
  assign done     = done_q;
  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;

  // Weight rows are laid out neuron-major, N_IN entries per neuron.
  assign in_addr  = i_cnt;
  assign w_addr   = WW'(n_cnt) * WW'(N_IN) + WW'(i_cnt);

  // Next-state, counter controls and outputs; the start request is only honoured from IDLE.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    i_clr      = 1'b0;
    i_en       = 1'b0;
    n_clr      = 1'b0;
    n_en       = 1'b0;
    rd_en      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = RUN;
          i_clr   = 1'b1;
          n_clr   = 1'b1;
        end
      end
      RUN: begin
        rd_en = 1'b1;
        i_en  = 1'b1;
        if (i_tc) begin
          state_d = WAIT;
          wait_d  = 1'b0;
        end
      end
      WAIT: begin
        // Last read data returns in the first drain cycle; its accumulate lands on that
        // cycle's closing edge, so the sum is stable for capture at the second edge.
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          wait_d     = 1'b0;
          state_d    = EMIT;
          out_data_d = mac_acc;
          out_idx_d  = n_cnt;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          i_clr = 1'b1;
          if (n_tc) begin
            n_clr   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            n_en    = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // MAC strobes trail the read strobe by the one-cycle buffer latency.
    mac_en_d  = rd_en;
    mac_clr_d = rd_en && (i_cnt == '0);
  end

  // State and registered outputs; reset drops any frame in flight without a result or done.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      wait_q     <= 1'b0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      mac_en_q   <= mac_en_d;
      mac_clr_q  <= mac_clr_d;
      done_q     <= done_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

endmodule

// File: tb/tb_cnn_mac_scheduler.sv
// Bench for cnn_mac_scheduler: buffer and wrapping MAC models, directed frames, result scoreboard.
// Latency: expects done N_OUT*(N_IN+3) edges after start, plus any stall cycles.
// Backpressure: drives out_ready low during one EMIT to check hold behaviour.
module tb_cnn_mac_scheduler;

  localparam int N_IN  = 16;
  localparam int N_OUT = 4;
  localparam int DW    = 8;
  localparam int AW    = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [3:0]    in_addr;
  logic [5:0]    w_addr;
  logic          rd_en;
  logic [DW-1:0] in_rdata = '0;
  logic [DW-1:0] w_rdata  = '0;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_en;
  logic          mac_clr;
  logic [AW-1:0] mac_acc = '0;
  logic [AW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  cnn_mac_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .rd_en     (rd_en),
    .in_rdata  (in_rdata),
    .w_rdata   (w_rdata),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .mac_acc   (mac_acc),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // Buffer model: one-cycle read latency.
  logic [DW-1:0] in_mem [N_IN];
  logic [DW-1:0] w_mem  [N_IN*N_OUT];
  always @(posedge Clk) begin
    if (rd_en) begin
      in_rdata <= in_mem[in_addr];
      w_rdata  <= w_mem[w_addr];
    end
  end

  // MAC model: wraps at AW bits, clr loads the product.
  always @(posedge Clk) begin
    logic [AW-1:0] p;
    p = AW'(mac_a) * AW'(mac_b);
    if (Rst)          mac_acc <= '0;
    else if (mac_en)  mac_acc <= mac_clr ? p : mac_acc + p;
  end

  typedef struct packed {
    logic [AW-1:0] data;
    logic [1:0]    idx;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_edge = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts done pulses and scores every accepted result against the queue.
  always @(negedge Clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      done_edge = edge_cnt;
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got data %0d idx %0d, expected no result", out_data, out_idx);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", longint'(out_data), longint'(e.data));
        check("sb_idx", longint'(out_idx), longint'(e.idx));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int mode);
    for (int j = 0; j < N_IN; j++) begin
      in_mem[j] = (mode == 2) ? 8'd255 : DW'(j + 1);
      for (int k = 0; k < N_OUT; k++) begin
        case (mode)
          0:       w_mem[k*N_IN + j] = 8'd1;
          1:       w_mem[k*N_IN + j] = DW'(k + 1);
          default: w_mem[k*N_IN + j] = 8'd255;
        endcase
      end
    end
  endtask

  task automatic push4(input logic [AW-1:0] v0, input logic [AW-1:0] v1,
                       input logic [AW-1:0] v2, input logic [AW-1:0] v3);
    sb_q.push_back({v0, 2'd0});
    sb_q.push_back({v1, 2'd1});
    sb_q.push_back({v2, 2'd2});
    sb_q.push_back({v3, 2'd3});
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = edge_cnt;
  endtask

  task automatic wait_done(input int d0, output int seen);
    seen = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge Clk);
      #1;
      if (done_cnt != d0) begin
        seen = done_edge;
        break;
      end
    end
    if (seen < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done within 300 cycles, expected one");
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, longint'({rd_en, mac_en, mac_clr, out_valid, busy, done,
                          out_data, out_idx, in_addr, w_addr}), 0);
  endtask

  // Plain frame: start, expect four results and done after the nominal latency.
  task automatic run_frame(input int mode, input logic [AW-1:0] v0, input logic [AW-1:0] v1,
                           input logic [AW-1:0] v2, input logic [AW-1:0] v3, input string tag);
    int t0, d0, de;
    tick();
    load(mode);
    push4(v0, v1, v2, v3);
    d0 = done_cnt;
    pulse_start(t0);
    wait_done(d0, de);
    check({tag, "_done_latency"}, de - t0, 76);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    @(negedge Clk);
    check({tag, "_done_one_cycle"}, longint'(done), 0);
    check({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  initial begin
    int t0, d0, de;
    Rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    load(0);
    tick();
    tick();
    // Reset and start together: reset must win, leaving the block idle.
    start = 1'b1;
    tick();
    Rst = 1'b0;
    start = 1'b0;
    @(negedge Clk);
    check_zero_outputs("reset_outputs");

    // Unit weights.
    run_frame(0, 16'd136, 16'd136, 16'd136, 16'd136, "ones");
    // Weights k+1 per neuron.
    run_frame(1, 16'd136, 16'd272, 16'd408, 16'd544, "ramp");

    // Backpressure: hold neuron 1's result for five edges.
    tick();
    load(1);
    push4(16'd136, 16'd272, 16'd408, 16'd544);
    d0 = done_cnt;
    pulse_start(t0);
    while (edge_cnt < t0 + 30) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (out_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge Clk);
      check("stall_valid", longint'(out_valid), 1);
      check("stall_data", longint'(out_data), 272);
      check("stall_idx", longint'(out_idx), 1);
      check("stall_rd_en", longint'(rd_en), 0);
    end
    @(posedge Clk);
    #1;
    out_ready = 1'b1;
    wait_done(d0, de);
    check("stall_done_latency", de - t0, 81);
    check("stall_sb_drained", sb_q.size(), 0);

    // Reset at cycle 10 of a frame, then a clean frame.
    tick();
    d0 = done_cnt;
    pulse_start(t0);
    while (edge_cnt < t0 + 10) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    check_zero_outputs("abort_outputs");
    repeat (100) @(negedge Clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_frame(1, 16'd136, 16'd272, 16'd408, 16'd544, "after_abort");

    // Second start while busy must be ignored.
    tick();
    load(0);
    push4(16'd136, 16'd136, 16'd136, 16'd136);
    d0 = done_cnt;
    pulse_start(t0);
    while (edge_cnt < t0 + 5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, de);
    check("restart_done_latency", de - t0, 76);
    repeat (100) @(negedge Clk);
    check("restart_done_count", done_cnt - d0, 1);
    check("restart_idle", longint'(busy), 0);
    check("restart_sb_drained", sb_q.size(), 0);

    // Saturated operands: 16 * 255 * 255 wraps to 57360 in 16 bits.
    run_frame(2, 16'd57360, 16'd57360, 16'd57360, 16'd57360, "wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cnn_mac_scheduler.md
CNN_MAC_SCHEDULER -- requirements
Module: cnn_mac_scheduler

Interface
REQ-001 SHALL have parameter N_IN, default 16, number of inputs per neuron.
REQ-002 SHALL have parameter N_OUT, default 4, number of neurons (weight sets).
REQ-003 SHALL have parameter DW, default 8, input and weight width.
REQ-004 SHALL have parameter AW, default 16, accumulator and output width.
REQ-005 SHALL use one clock, Clk; reset is synchronous and active-high, Rst.
REQ-006 Clk  input  1  rising-edge clock.
REQ-007 Rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle request to begin one frame of N_OUT neurons.
REQ-009 in_addr  output  clog2(N_IN)  input-buffer read address.
REQ-010 w_addr  output  clog2(N_IN*N_OUT)  weight-buffer read address.
REQ-011 rd_en  output  1  buffer read strobe; data returns on in_rdata/w_rdata one cycle later.
REQ-012 in_rdata, w_rdata  input  DW each  buffer read data.
REQ-013 mac_a, mac_b  output  DW each  MAC operands, combinationally equal to in_rdata and w_rdata.
REQ-014 mac_en, mac_clr  output  1 each  MAC accumulate strobe; clr loads the product instead of adding it.
REQ-015 mac_acc  input  AW  MAC accumulator, updated on the edge that samples mac_en.
REQ-016 out_data  output  AW  neuron result.
REQ-017 out_idx  output  clog2(N_OUT)  neuron index of out_data.
REQ-018 out_valid  output  1  result valid.
REQ-019 out_ready  input  1  consumer accepts the result.
REQ-020 busy  output  1  frame in progress.
REQ-021 done  output  1  one-cycle pulse at frame end.

Function
REQ-022 FSM states SHALL be IDLE, RUN, WAIT, EMIT.
- IDLE->RUN on start; neuron n=0, i=0.
REQ-023 RUN SHALL last exactly N_IN cycles.
- rd_en=1; in_addr=i; w_addr=n*N_IN+i; i increments each cycle.
REQ-024 mac_en SHALL be rd_en delayed one cycle.
- mac_clr=1 only with the first mac_en of each neuron.
REQ-025 WAIT SHALL last 2 cycles; mac_acc SHALL be captured into out_data, and n into out_idx, on the final WAIT edge.
REQ-026 EMIT SHALL assert out_valid; out_data and out_idx SHALL remain stable until the edge where out_valid&&out_ready.
REQ-027 On handshake: if n<N_OUT-1 then n++, i=0, ->RUN; else ->IDLE with done=1 for one cycle.
REQ-028 With out_ready tied high, each neuron SHALL take N_IN+3 cycles.
- done SHALL assert N_OUT*(N_IN+3) cycles after the start-sampling edge (76 at defaults).
REQ-029 start SHALL be ignored while busy; busy=1 in RUN, WAIT and EMIT.
REQ-030 Width rule: mac_acc SHALL pass to out_data unmodified; overflow wraps in the MAC, with no saturation here.
REQ-031 rd_en and mac_en SHALL never assert outside RUN and the first WAIT cycle.

Reset
REQ-032 Rst SHALL force IDLE, counters 0, and rd_en, mac_en, mac_clr, out_valid, busy, done, out_data, out_idx, in_addr and w_addr all 0.
REQ-033 Rst mid-frame SHALL abort without a partial result or done pulse.
- A following start SHALL produce a correct full frame.
REQ-034 Rst and start in the same cycle: Rst SHALL win.

Structure
REQ-035 Package cnn_pkg SHALL hold N_IN, N_OUT, DW, AW defaults and the FSM state enum.
REQ-036 Sub-module cnn_idx_counter (wrapping counter with clear, enable and terminal-count output) SHALL be instantiated twice, for i and n.

Verification
REQ-037 Inputs 1..16, all weights 1, out_ready=1, start -> four results of 136, idx 0..3, done at cycle 76.
REQ-038 Inputs 1..16, weights of neuron k = k+1 -> out_data 136, 272, 408, 544 in order.
REQ-039 out_ready low for 5 cycles during neuron 1 EMIT -> out_valid held, out_data=272 stable, no rd_en, done delayed 5 cycles.
REQ-040 Rst for 1 cycle at cycle 10 of a frame -> all outputs 0 next cycle, no done; next start yields 136, 272, 408, 544.
REQ-041 Second start pulse at cycle 5 of a frame -> ignored; exactly four results and one done.
REQ-042 All inputs and weights 255 with a wrapping bench MAC model -> every out_data = 57360.
